// File: rtl/alu_share_arbiter_if.sv
// rtl/alu_share_arbiter_if.sv - request, ALU-drive and response bundle for the shared ALU arbiter
interface alu_share_arbiter_if;
    logic       req0_valid;
    logic       req0_ready;
    logic [3:0] req0_ctrl;
    logic [7:0] req0_a;
    logic [7:0] req0_b;
    logic       req1_valid;
    logic       req1_ready;
    logic [3:0] req1_ctrl;
    logic [7:0] req1_a;
    logic [7:0] req1_b;
    logic [3:0] alu_control;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [7:0] alu_result;
    logic       alu_zero;
    logic       rsp0_valid;
    logic       rsp1_valid;
    logic [7:0] rsp_result;
    logic       rsp_zero;

    modport slave (
        input  req0_valid, req0_ctrl, req0_a, req0_b,
        input  req1_valid, req1_ctrl, req1_a, req1_b,
        input  alu_result, alu_zero,
        output req0_ready, req1_ready,
        output alu_control, alu_a, alu_b,
        output rsp0_valid, rsp1_valid, rsp_result, rsp_zero
    );

    modport master (
        output req0_valid, req0_ctrl, req0_a, req0_b,
        output req1_valid, req1_ctrl, req1_a, req1_b,
        output alu_result, alu_zero,
        input  req0_ready, req1_ready,
        input  alu_control, alu_a, alu_b,
        input  rsp0_valid, rsp1_valid, rsp_result, rsp_zero
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - two-requester priority arbiter with starvation bound feeding a shared ALU
module alu_share_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                i_clk,
    input  logic                i_reset,
    alu_share_arbiter_if.slave  bus
);
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] r_starve_cnt;
    logic       r_s1_valid;
    logic       r_s1_id;
    logic [3:0] r_alu_control;
    logic [7:0] r_alu_a;
    logic [7:0] r_alu_b;
    logic       r_rsp0_valid;
    logic       r_rsp1_valid;
    logic [7:0] r_rsp_result;
    logic       r_rsp_zero;

    logic       w_force1;
    logic       w_req0_ready;
    logic       w_req1_ready;
    logic       w_accept;

    // Requester 0 wins by default; requester 1 wins alone or once its wait hits the limit.
    assign w_force1     = (r_starve_cnt == LIMIT);
    assign w_req1_ready = !i_reset && bus.req1_valid && (!bus.req0_valid || w_force1);
    assign w_req0_ready = !i_reset && bus.req0_valid && !w_req1_ready;
    assign w_accept     = w_req0_ready || w_req1_ready;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_starve_cnt <= 4'd0;
        end else if (!bus.req1_valid || w_req1_ready) begin
            r_starve_cnt <= 4'd0;
        end else if (r_starve_cnt != LIMIT) begin
            r_starve_cnt <= r_starve_cnt + 4'd1;
        end
    end

    // Issue stage: operands hold when idle so the ALU inputs stay quiet.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_s1_valid    <= 1'b0;
            r_s1_id       <= 1'b0;
            r_alu_control <= 4'b0000;
            r_alu_a       <= 8'd0;
            r_alu_b       <= 8'd0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_req1_ready) begin
                r_s1_id       <= 1'b1;
                r_alu_control <= bus.req1_ctrl;
                r_alu_a       <= bus.req1_a;
                r_alu_b       <= bus.req1_b;
            end else if (w_req0_ready) begin
                r_s1_id       <= 1'b0;
                r_alu_control <= bus.req0_ctrl;
                r_alu_a       <= bus.req0_a;
                r_alu_b       <= bus.req0_b;
            end
        end
    end

    // Response stage: one-cycle strobe routed back to the requester that issued.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_rsp_result <= 8'd0;
            r_rsp_zero   <= 1'b0;
        end else if (r_s1_valid) begin
            r_rsp0_valid <= !r_s1_id;
            r_rsp1_valid <= r_s1_id;
            r_rsp_result <= bus.alu_result;
            r_rsp_zero   <= bus.alu_zero;
        end else begin
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
        end
    end

    assign bus.req0_ready  = w_req0_ready;
    assign bus.req1_ready  = w_req1_ready;
    assign bus.alu_control = r_alu_control;
    assign bus.alu_a       = r_alu_a;
    assign bus.alu_b       = r_alu_b;
    assign bus.rsp0_valid  = r_rsp0_valid;
    assign bus.rsp1_valid  = r_rsp1_valid;
    assign bus.rsp_result  = r_rsp_result;
    assign bus.rsp_zero    = r_rsp_zero;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - directed bench for alu_share_arbiter with a behavioural ALU
module tb_alu_share_arbiter;
    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    alu_share_arbiter_if bus ();

    alu_share_arbiter #(.STARVE_LIMIT(4)) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        bus.alu_result = 8'h00;
        case (bus.alu_control)
            4'b0000: bus.alu_result = bus.alu_a & bus.alu_b;
            4'b0001: bus.alu_result = bus.alu_a | bus.alu_b;
            4'b0010: bus.alu_result = bus.alu_a + bus.alu_b;
            4'b0011: bus.alu_result = bus.alu_a ^ bus.alu_b;
            4'b0100: bus.alu_result = ~bus.alu_a;
            4'b0110: bus.alu_result = bus.alu_a - bus.alu_b;
            default: bus.alu_result = 8'h00;
        endcase
        bus.alu_zero = (bus.alu_result == 8'h00);
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set0(input logic v, input logic [3:0] c, input logic [7:0] a, input logic [7:0] b);
        bus.req0_valid = v;
        bus.req0_ctrl  = c;
        bus.req0_a     = a;
        bus.req0_b     = b;
    endtask

    task automatic set1(input logic v, input logic [3:0] c, input logic [7:0] a, input logic [7:0] b);
        bus.req1_valid = v;
        bus.req1_ctrl  = c;
        bus.req1_a     = a;
        bus.req1_b     = b;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        set0(1'b0, 4'h0, 8'h00, 8'h00);
        set1(1'b0, 4'h0, 8'h00, 8'h00);
        tick();
        tick();

        // Reset state, and readies masked while reset is high.
        set0(1'b1, 4'h2, 8'h11, 8'h22);
        set1(1'b1, 4'h3, 8'h33, 8'h44);
        #1;
        chk("rst_ready0", 16'(bus.req0_ready), 16'h0);
        chk("rst_ready1", 16'(bus.req1_ready), 16'h0);
        tick();
        chk("rst_alu_control", 16'(bus.alu_control), 16'h0);
        chk("rst_alu_a", 16'(bus.alu_a), 16'h0);
        chk("rst_alu_b", 16'(bus.alu_b), 16'h0);
        chk("rst_rsp_result", 16'(bus.rsp_result), 16'h0);
        chk("rst_rsp_zero", 16'(bus.rsp_zero), 16'h0);
        chk("rst_rsp0_valid", 16'(bus.rsp0_valid), 16'h0);
        chk("rst_rsp1_valid", 16'(bus.rsp1_valid), 16'h0);
        set0(1'b0, 4'h0, 8'h00, 8'h00);
        set1(1'b0, 4'h0, 8'h00, 8'h00);
        reset = 1'b0;
        tick();

        // ADD 5+3 from requester 0.
        set0(1'b1, 4'b0010, 8'h05, 8'h03);
        #1;
        chk("add_ready0", 16'(bus.req0_ready), 16'h1);
        chk("add_ready1", 16'(bus.req1_ready), 16'h0);
        tick();
        set0(1'b0, 4'h0, 8'h00, 8'h00);
        chk("add_alu_control", 16'(bus.alu_control), 16'h2);
        chk("add_alu_a", 16'(bus.alu_a), 16'h05);
        chk("add_alu_b", 16'(bus.alu_b), 16'h03);
        chk("add_rsp0_early", 16'(bus.rsp0_valid), 16'h0);
        tick();
        chk("add_rsp0_valid", 16'(bus.rsp0_valid), 16'h1);
        chk("add_rsp1_valid", 16'(bus.rsp1_valid), 16'h0);
        chk("add_result", 16'(bus.rsp_result), 16'h08);
        chk("add_zero", 16'(bus.rsp_zero), 16'h0);
        tick();
        chk("add_rsp0_oneshot", 16'(bus.rsp0_valid), 16'h0);

        // SUB 2A-2A from requester 1 alone.
        set1(1'b1, 4'b0110, 8'h2A, 8'h2A);
        #1;
        chk("sub_ready1", 16'(bus.req1_ready), 16'h1);
        tick();
        set1(1'b0, 4'h0, 8'h00, 8'h00);
        tick();
        chk("sub_rsp1_valid", 16'(bus.rsp1_valid), 16'h1);
        chk("sub_rsp0_valid", 16'(bus.rsp0_valid), 16'h0);
        chk("sub_result", 16'(bus.rsp_result), 16'h00);
        chk("sub_zero", 16'(bus.rsp_zero), 16'h1);
        tick();

        // Simultaneous: req0 ADD FF+01 wins, req1 XOR follows next cycle.
        set0(1'b1, 4'b0010, 8'hFF, 8'h01);
        set1(1'b1, 4'b0011, 8'hF0, 8'h0F);
        #1;
        chk("sim_ready0", 16'(bus.req0_ready), 16'h1);
        chk("sim_ready1", 16'(bus.req1_ready), 16'h0);
        tick();
        set0(1'b0, 4'h0, 8'h00, 8'h00);
        #1;
        chk("sim_ready1_next", 16'(bus.req1_ready), 16'h1);
        tick();
        set1(1'b0, 4'h0, 8'h00, 8'h00);
        chk("sim_rsp0_valid", 16'(bus.rsp0_valid), 16'h1);
        chk("sim_rsp0_result", 16'(bus.rsp_result), 16'h00);
        chk("sim_rsp0_zero", 16'(bus.rsp_zero), 16'h1);
        tick();
        chk("sim_rsp1_valid", 16'(bus.rsp1_valid), 16'h1);
        chk("sim_rsp1_rsp0", 16'(bus.rsp0_valid), 16'h0);
        chk("sim_rsp1_result", 16'(bus.rsp_result), 16'hFF);
        chk("sim_rsp1_zero", 16'(bus.rsp_zero), 16'h0);
        tick();

        // Starvation: both held; req1 wins in cycles 4 and 9, responses follow in order.
        set0(1'b1, 4'b0010, 8'h10, 8'h01);
        set1(1'b1, 4'b0001, 8'h20, 8'h02);
        for (int c = 0; c < 12; c++) begin
            #1;
            if (c < 10) begin
                chk($sformatf("starve_ready1_c%0d", c), 16'(bus.req1_ready), 16'((c == 4) || (c == 9)));
                chk($sformatf("starve_ready0_c%0d", c), 16'(bus.req0_ready), 16'(!((c == 4) || (c == 9))));
            end
            if (c >= 2) begin
                chk($sformatf("starve_rsp1_c%0d", c), 16'(bus.rsp1_valid), 16'((c == 6) || (c == 11)));
                chk($sformatf("starve_result_c%0d", c), 16'(bus.rsp_result),
                    ((c == 6) || (c == 11)) ? 16'h22 : 16'h11);
            end
            tick();
        end
        set0(1'b0, 4'h0, 8'h00, 8'h00);
        set1(1'b0, 4'h0, 8'h00, 8'h00);
        tick();
        tick();

        // Dropping req1 while waiting clears the counter.
        set0(1'b1, 4'b0010, 8'h01, 8'h01);
        set1(1'b1, 4'b0001, 8'h01, 8'h02);
        tick();
        tick();
        set1(1'b0, 4'h0, 8'h00, 8'h00);
        tick();
        set1(1'b1, 4'b0001, 8'h01, 8'h02);
        for (int c = 0; c < 5; c++) begin
            #1;
            chk($sformatf("drop_ready1_c%0d", c), 16'(bus.req1_ready), 16'(c == 4));
            tick();
        end
        set0(1'b0, 4'h0, 8'h00, 8'h00);
        set1(1'b0, 4'h0, 8'h00, 8'h00);
        tick();
        tick();

        // Back-to-back: eight req0 ADDs c+1, responses 1..8 on consecutive cycles.
        for (int c = 0; c < 10; c++) begin
            if (c < 8) set0(1'b1, 4'b0010, 8'(c), 8'h01);
            else       set0(1'b0, 4'h0, 8'h00, 8'h00);
            #1;
            if (c >= 2) begin
                chk($sformatf("b2b_rsp0_c%0d", c), 16'(bus.rsp0_valid), 16'h1);
                chk($sformatf("b2b_result_c%0d", c), 16'(bus.rsp_result), 16'(c - 1));
            end
            tick();
        end
        chk("b2b_rsp0_done", 16'(bus.rsp0_valid), 16'h0);
        tick();

        // Reset mid-flight discards the accepted transaction.
        set0(1'b1, 4'b0010, 8'h03, 8'h04);
        tick();
        set0(1'b0, 4'h0, 8'h00, 8'h00);
        reset = 1'b1;
        tick();
        chk("midrst_rsp0", 16'(bus.rsp0_valid), 16'h0);
        chk("midrst_rsp1", 16'(bus.rsp1_valid), 16'h0);
        chk("midrst_alu_control", 16'(bus.alu_control), 16'h0);
        chk("midrst_alu_a", 16'(bus.alu_a), 16'h0);
        chk("midrst_result", 16'(bus.rsp_result), 16'h0);
        chk("midrst_zero", 16'(bus.rsp_zero), 16'h0);
        set1(1'b1, 4'b0000, 8'hF0, 8'h3C);
        #1;
        chk("midrst_ready1_masked", 16'(bus.req1_ready), 16'h0);
        tick();
        chk("midrst_rsp0_late", 16'(bus.rsp0_valid), 16'h0);
        reset = 1'b0;
        #1;
        chk("postrst_ready1", 16'(bus.req1_ready), 16'h1);
        tick();
        set1(1'b0, 4'h0, 8'h00, 8'h00);
        chk("postrst_early", 16'(bus.rsp1_valid), 16'h0);
        tick();
        chk("postrst_rsp1", 16'(bus.rsp1_valid), 16'h1);
        chk("postrst_result", 16'(bus.rsp_result), 16'h30);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Two-requester arbiter and issue sequencer for the shared 8-bit combinational ALU. It sits beside the EX stage and shares one ALU instance between the pipeline (requester 0) and an auxiliary requester (requester 1, e.g. debug/address unit). It drives a registered ALU operation every cycle and returns the result to the originating requester two cycles after acceptance. Requester 0 has priority, but a starvation counter bounds how long requester 1 can be held off.

## Interface
- STARVE_LIMIT, 4: consecutive denied cycles after which requester 1 is forced to win; legal range 1-15.
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req0_valid / req1_valid  in  1  requester has an operation pending.
- req0_ready / req1_ready  out  1  grant; the transfer happens when valid && ready in the same cycle (combinational).
- req0_ctrl / req1_ctrl  in  4  ALU control code: AND 0000, OR 0001, ADD 0010, XOR 0011, NOT 0100, SUB 0110, JUMP 1100.
- req0_a, req0_b / req1_a, req1_b  in  8  operands.
- alu_control  out  4  registered control to the ALU.
- alu_a, alu_b  out  8  registered operands to the ALU.
- alu_result  in  8  combinational ALU result.
- alu_zero  in  1  ALU zero flag.
- rsp0_valid / rsp1_valid  out  1  one-cycle response strobe.
- rsp_result  out  8  registered result, shared by both responses.
- rsp_zero  out  1  registered zero flag.

## Operation
- Arbitration is evaluated every cycle:
  - force1 = (starve_cnt == STARVE_LIMIT).
  - req1_ready = req1_valid && (!req0_valid || force1).
  - req0_ready = req0_valid && !req1_ready.
  - At most one ready is high in any cycle.
- Starvation counter (4 bits):
  - Increments when req1_valid && !req1_ready, saturating at STARVE_LIMIT.
  - Clears to 0 when req1 is accepted or when req1_valid is low.
- Issue stage (s1): on accept, capture alu_control, alu_a and alu_b from the winner, set s1_valid = 1, and set s1_id to the winner index. With no accept, s1_valid = 0 and the ALU registers hold their previous values.
- Response stage (s2):
  - When s1_valid, capture rsp_result <= alu_result and rsp_zero <= alu_zero, and pulse rsp{s1_id}_valid.
  - Otherwise both rsp valids are 0 and rsp_result/rsp_zero hold.
- Control codes pass through unchanged; the arbiter does not decode them. Arithmetic width, wrap-around and the zero flag are the ALU's responsibility (results are mod 256).
- Responses have no backpressure. Each requester must sample its rsp in the strobe cycle.
- Responses return in acceptance order, and no transaction is dropped or duplicated.
- Reset values: alu_control 4'b0000, alu_a 0, alu_b 0, rsp_result 0, rsp_zero 0, rsp0_valid 0, rsp1_valid 0, s1_valid 0, starve_cnt 0.
- While reset is high, req0_ready and req1_ready are forced to 0.

## Timing
- Accept in cycle N. The ALU inputs are valid in N+1. rsp*_valid and rsp_result are valid in N+2 for exactly one cycle.
- Full throughput: one accept per cycle, giving back-to-back responses with latency 2.
- Simultaneous requests without force1: requester 0 wins.
- With req0 held continuously and req1 valid:
  - req1 is denied for STARVE_LIMIT cycles.
  - On the next cycle req1 wins and req0 is stalled for that single cycle.
  - The counter then returns to 0.
- Requester 0 requires no fairness counter; it can lose at most one cycle per STARVE_LIMIT+1 cycles.
- Reset asserted mid-operation: in-flight s1 and s2 transactions are discarded and no rsp strobe is produced. The first accept is possible in the cycle after reset deasserts.
- Requester 1 dropping valid while waiting clears the counter; a later request starts counting from 0.

## Test plan
- ADD accept: req0 with ctrl 0010, a=8'h05, b=8'h03 in cycle N -> alu_control=0010 in N+1; rsp0_valid=1, rsp_result=8'h08, rsp_zero=0 in N+2; rsp1_valid=0.
- SUB with zero flag: req1 alone, ctrl 0110, a=8'h2A, b=8'h2A -> rsp1_valid=1, rsp_result=8'h00, rsp_zero=1 two cycles later.
- Simultaneous requests: req0 ADD 8'hFF+8'h01 and req1 XOR 8'hF0^8'h0F in the same cycle:
  - Cycle N: req0_ready=1, req1_ready=0; rsp0 result 8'h00 with zero=1 (wrap) at N+2.
  - Next cycle: req1 is accepted; rsp1 result 8'hFF at N+3.
- Starvation with STARVE_LIMIT=4: req0 and req1 continuously valid from cycle 0:
  - req1_ready is low in cycles 0-3 and high in cycle 4, when req0_ready=0.
  - Cycles 5-8 are denied again, and req1 wins again in cycle 9.
- Back-to-back throughput: 8 consecutive req0 ADDs (i+1 for i=0..7) -> rsp0_valid high for 8 consecutive cycles, with results 1..8 in order.
- Reset mid-flight: accept req0 in cycle N, assert reset in N+1 -> no rsp strobe; all outputs at reset values; a new accept after reset completes normally with latency 2.
